fft_io_sched: RTL
=================

FFT_IO_SCHED -- requirements
Module: fft_io_sched

Interface
REQ-001 Parameter A_BIT, default 8, per-bank RAM address width; frame length N = 4*2^A_BIT samples (1024 at default).
REQ-002 Parameter D_BIT, default 17, FFT word width including expansion bit.
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 iRESET  in  1  asynchronous, active-low reset.
REQ-005 iEN  in  1  arm request; a frame starts when sampled high in IDLE.
REQ-006 iDATA  in  D_BIT-1  ADC sample stream.
REQ-007 iVALID / oREADY  in / out  1 / 1  ADC stream handshake.
REQ-008 oDATA  out  D_BIT-1  sample to FFT core iDATA.
REQ-009 oADDR_WR  out  A_BIT  write address, shared by all four banks.
REQ-010 oWE  out  4  per-bank write enable, one-hot or zero.
REQ-011 oADDR_RD  out  A_BIT  read address, shared by all four banks.
REQ-012 oSTART  out  1  one-cycle FFT start pulse.
REQ-013 iFFT_RDY  in  1  FFT core done level.
REQ-014 iRE_0..iRE_3  in  D_BIT each  real result from banks 0..3; data valid 1 cycle after oADDR_RD.
REQ-015 oDATA_RE / oVALID / iREADY / oLAST  out / out / in / out  D_BIT / 1 / 1 / 1  result stream; oLAST marks sample N-1.
REQ-016 oBUSY  out  1  high in any state except IDLE.

Function
REQ-017 FSM states IDLE, LOAD, START, WAIT, UNLOAD; transitions only as REQ-018..REQ-022.
REQ-018 IDLE->LOAD when iEN=1; load counter n cleared to 0.
REQ-019 LOAD: oREADY=1; on iVALID&oREADY, next cycle oDATA=sample, oADDR_WR=n[A_BIT+1:2], oWE=one-hot(n[1:0]) for exactly one cycle; n increments; accepting n=N-1 moves to START, and oREADY is 0 from that next cycle.
REQ-020 START lasts one cycle and drives oSTART=1; it begins the cycle after the final write, so the write and the pulse never overlap; next state WAIT.
REQ-021 WAIT->UNLOAD on rising edge of iFFT_RDY (registered previous value 0, current 1); a level already high on WAIT entry is not an edge.
REQ-022 UNLOAD: reads issue in index order k=0..N-1, oADDR_RD=k[A_BIT+1:2], bank k[1:0] registered alongside and used to select iRE_x next cycle into a 2-entry output FIFO.
REQ-023 Read issued in a cycle iff occupancy + in-flight - pop < 2 and k<=N-1; with iREADY held high, throughput is 1 sample/cycle after 2-cycle initial latency.
REQ-024 oVALID = FIFO non-empty; oDATA_RE/oLAST stable while oVALID&!iREADY; oLAST=1 only with sample N-1.
REQ-025 Accepting oLAST returns to IDLE the next cycle; FIFO and counters are then empty/zero.
REQ-026 iEN ignored outside IDLE; iVALID ignored outside LOAD; iFFT_RDY ignored outside WAIT.
REQ-027 Counters wrap never: n and k saturate at N-1 via state exit; no write or read beyond index N-1.

Reset
REQ-028 iRESET=0 forces IDLE immediately, any cycle, mid-frame included: oREADY, oWE, oSTART, oVALID, oLAST, oBUSY=0; oDATA, oADDR_WR, oADDR_RD, oDATA_RE=0; FIFO emptied; counters 0; edge register 0.
REQ-029 After release, first action requires iEN=1; partial frames are discarded, not resumed.

Structure
REQ-030 State encoding, N derivation and FIFO depth constant (2) live in the shared FFT defines package beside A_BIT/D_BIT.
REQ-031 One sub-module: fft_out_fifo (2-entry, D_BIT+1 wide, synchronous, with occupancy count); the rest is flat.

Verification (A_BIT=2, N=16 unless noted)
REQ-032 Reset, iEN=1, 16 samples 1..16 with iVALID always high -> bank b addr a holds 4a+b+1; oWE one-hot each cycle; oSTART exactly 1 cycle, 1 cycle after the 16th write.
REQ-033 iVALID gapped 1-of-3 cycles -> same RAM contents; no write without handshake; oREADY=0 from the cycle after sample 16.
REQ-034 iFFT_RDY high before WAIT entry, low 3 cycles, then high -> UNLOAD starts only after that rising edge.
REQ-035 Model RAM with result=address index k; iREADY=1 -> oDATA_RE=0..15 consecutive cycles, oLAST on 15, IDLE next cycle.
REQ-036 iREADY random 50% -> identical sequence 0..15, no drop/duplicate, outputs stable under stall, FIFO occupancy never >2.
REQ-037 iRESET low after sample 7, then high with iEN=1 -> fresh frame from index 0, no oSTART from the aborted frame.

Source files
------------

// File: rtl/fft_io_sched_pkg.sv
// Shared FFT defines: default word/address widths, frame-length derivation,
// output FIFO depth and the I/O scheduler state encoding.
package fft_io_sched_pkg;

    // Default per-bank RAM address width and FFT word width (incl. growth bit)
    localparam int FFT_A_BIT = 8;
    localparam int FFT_D_BIT = 17;

    // Depth of the result FIFO; the read-issue rule relies on this being 2
    localparam int FIFO_DEPTH = 2;

    // Scheduler state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_START  = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_UNLOAD = 3'd4;

    // Samples per frame: four interleaved banks of 2^a_bit words each
    function automatic int frame_len(input int a_bit);
        return 4 << a_bit;
    endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry synchronous FIFO used to decouple the banked RAM read pipeline
// from the downstream result stream.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push, din  : write strobe and data (caller never pushes when full)
//   pop        : read strobe (caller only pops when non-empty)
//   dout       : head entry, held stable until popped
//   empty      : no entries stored
//   count      : current occupancy, 0..2
module fft_out_fifo
    import fft_io_sched_pkg::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A push into a non-empty FIFO lands in the other slot, so the head
    // never changes while it is waiting to be popped.
    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fft_io_sched.sv
// FFT I/O scheduler: loads one frame of ADC samples into four interleaved
// RAM banks, pulses the FFT core start, waits for the core to finish, then
// streams the real results back out in natural index order.
//
// Ports:
//   iCLK, iRESET        : clock, asynchronous active-low reset
//   iEN                 : arm request, sampled only while idle
//   iDATA/iVALID/oREADY : ADC sample stream in
//   oDATA/oADDR_WR/oWE  : bank write port (address shared, one-hot enable)
//   oADDR_RD            : bank read address (shared by all banks)
//   oSTART              : one-cycle FFT start pulse
//   iFFT_RDY            : FFT core done level (rising edge is used)
//   iRE_0..iRE_3        : bank read data, valid one cycle after oADDR_RD
//   oDATA_RE/oVALID/iREADY/oLAST : result stream out, oLAST on sample N-1
//   oBUSY               : high whenever a frame is in progress
module fft_io_sched
    import fft_io_sched_pkg::*;
#(
    parameter int A_BIT = FFT_A_BIT,
    parameter int D_BIT = FFT_D_BIT
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iEN,
    input  logic [D_BIT-2:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-2:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oADDR_RD,
    output logic             oSTART,
    input  logic             iFFT_RDY,
    input  logic [D_BIT-1:0] iRE_0,
    input  logic [D_BIT-1:0] iRE_1,
    input  logic [D_BIT-1:0] iRE_2,
    input  logic [D_BIT-1:0] iRE_3,
    output logic [D_BIT-1:0] oDATA_RE,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY
);

    localparam int             N        = frame_len(A_BIT);
    localparam int             IW       = A_BIT + 2;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   n;          // load index
    logic [IW-1:0]   k;          // unload read index
    logic            rd_done;    // index N-1 has been issued
    logic            fft_rdy_q;

    logic            accept;
    logic            rdy_edge;
    logic            pop;
    logic            issue;
    logic [2:0]      pending;
    logic [1:0]      occ;

    logic [1:0]      bank_p1;
    logic            vld_p1;
    logic            last_p1;
    logic [D_BIT-1:0] re_sel_p1;
    logic [D_BIT:0]  fifo_head;
    logic            fifo_empty;

    assign oREADY   = (state == ST_LOAD);
    assign oBUSY    = (state != ST_IDLE);
    assign accept   = oREADY && iVALID;
    assign rdy_edge = iFFT_RDY && !fft_rdy_q;
    assign pop      = oVALID && iREADY;

    // Entries that will be in the FIFO after this cycle's pop, counting the
    // read already in flight; a new read is only issued if it will fit.
    assign pending  = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue    = (state == ST_UNLOAD) && !rd_done && (pending < 3'd2);
    assign oADDR_RD = k[IW-1:2];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (iEN) state_nxt = ST_LOAD;
            ST_LOAD:   if (accept && (n == LAST_IDX)) state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (rdy_edge) state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (pop && oLAST) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= ST_IDLE;
            n         <= '0;
            k         <= '0;
            rd_done   <= 1'b0;
            fft_rdy_q <= 1'b0;
            oDATA     <= '0;
            oADDR_WR  <= '0;
            oWE       <= 4'b0000;
            oSTART    <= 1'b0;
            bank_p1   <= 2'd0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fft_rdy_q <= iFFT_RDY;

            // Registered so the pulse lands the cycle after the final write
            oSTART    <= (state == ST_START);

            // Load stage: accepted sample -> bank write next cycle
            oWE <= 4'b0000;
            if (accept) begin
                oDATA    <= iDATA;
                oADDR_WR <= n[IW-1:2];
                oWE      <= 4'b0001 << n[1:0];
                if (n != LAST_IDX) begin
                    n <= n + IW'(1);
                end
            end

            // Read stage p0 -> p1: address out now, bank data returns next cycle
            vld_p1 <= issue;
            if (issue) begin
                bank_p1 <= k[1:0];
                last_p1 <= (k == LAST_IDX);
                if (k == LAST_IDX) begin
                    rd_done <= 1'b1;
                end else begin
                    k <= k + IW'(1);
                end
            end

            // Counters are zero whenever the scheduler sits in IDLE
            if (state_nxt == ST_IDLE) begin
                n       <= '0;
                k       <= '0;
                rd_done <= 1'b0;
            end
        end
    end

    // Read stage p1: pick the returning bank and push into the result FIFO
    always_comb begin
        case (bank_p1)
            2'd0:    re_sel_p1 = iRE_0;
            2'd1:    re_sel_p1 = iRE_1;
            2'd2:    re_sel_p1 = iRE_2;
            default: re_sel_p1 = iRE_3;
        endcase
    end

    fft_out_fifo #(
        .W (D_BIT + 1)
    ) u_fifo (
        .clk   (iCLK),
        .rst_n (iRESET),
        .push  (vld_p1),
        .din   ({last_p1, re_sel_p1}),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (occ)
    );

    assign oVALID   = !fifo_empty;
    assign oLAST    = fifo_head[D_BIT];
    assign oDATA_RE = fifo_head[D_BIT-1:0];

endmodule
